// File: rtl/accum_table_read_ctrl_if.sv
// Table-read and output-stream signals of the accumulator drain controller.
// The master side belongs to the controller, the slave side to the table and consumer.
interface accum_table_read_ctrl_if #(
  parameter int AW = 10,
  parameter int WW = 512,
  parameter int RW = 7,
  parameter int CW = 3
);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [WW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_data;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col_blk;
  logic          out_last;

  modport master (
    output rd_en, rd_addr, out_valid, out_data, out_row, out_col_blk, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_valid, out_data, out_row, out_col_blk, out_last,
    output rd_data, out_ready
  );
endinterface

// File: rtl/accum_table_read_ctrl.sv
// Drains the accumulator table row-major into a valid/ready stream, undoing the
// write-side row reversal; a 2-entry FIFO absorbs the 1-cycle table read latency.
module accum_table_read_ctrl #(
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16,
  parameter int DATA_W       = 32
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          start,
  input  logic [$clog2(MAX_OUT_ROWS):0]                 cfg_rows,
  input  logic [$clog2(MAX_OUT_COLS/SYS_ARR_COLS):0]    cfg_col_blks,
  accum_table_read_ctrl_if.master                       bus,
  output logic                                          busy,
  output logic                                          done
);

  localparam int NCB            = MAX_OUT_COLS / SYS_ARR_COLS;
  localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS * NCB;
  localparam int AW             = $clog2(NUM_ACCUM_ROWS);
  localparam int RW             = $clog2(MAX_OUT_ROWS);
  localparam int CW             = (NCB > 1) ? $clog2(NCB) : 1;
  localparam int RCW            = $clog2(MAX_OUT_ROWS) + 1;
  localparam int CCW            = $clog2(NCB) + 1;
  localparam int WW             = SYS_ARR_COLS * DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [RCW-1:0]  rows_q, rows_d;
  logic [CCW-1:0]  cols_q, cols_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;

  logic            infl_q, infl_d;
  logic [RW-1:0]   infl_row_q, infl_row_d;
  logic [CW-1:0]   infl_col_q, infl_col_d;
  logic            infl_last_q, infl_last_d;

  logic [1:0]      fifo_cnt_q, fifo_cnt_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [WW-1:0]   fifo_data_q [2];
  logic [WW-1:0]   fifo_data_d [2];
  logic [RW-1:0]   fifo_row_q  [2];
  logic [RW-1:0]   fifo_row_d  [2];
  logic [CW-1:0]   fifo_col_q  [2];
  logic [CW-1:0]   fifo_col_d  [2];
  logic            fifo_last_q [2];
  logic            fifo_last_d [2];

  logic            pop_s;
  logic            rd_en_s;
  logic            last_col_s;
  logic            last_rd_s;
  logic [2:0]      occ_s;
  logic [31:0]     addr_s;

  // Read issue decision, last-read detection and reversed-row address.
  always_comb begin
    pop_s      = bus.out_valid & bus.out_ready;
    // Words held or in flight after this cycle's pop must leave room for one more.
    occ_s      = 3'(fifo_cnt_q) + 3'(infl_q) - 3'(pop_s);
    rd_en_s    = (state_q == RUN) && (occ_s < 3'd2);
    last_col_s = (CCW'(col_q) == (cols_q - CCW'(1'b1)));
    last_rd_s  = last_col_s && (RCW'(row_q) == (rows_q - RCW'(1'b1)));
    addr_s     = 32'(col_q) * 32'(MAX_OUT_ROWS)
               + (32'(row_q) / 32'(SYS_ARR_ROWS)) * 32'(SYS_ARR_ROWS)
               + (32'(SYS_ARR_ROWS) - 32'd1 - (32'(row_q) % 32'(SYS_ARR_ROWS)));
  end

  // Next-state logic, config latching and traversal counters.
  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((cfg_rows != '0) && (cfg_col_blks != '0)) begin
            state_d = RUN;
            rows_d  = cfg_rows;
            cols_d  = cfg_col_blks;
            row_d   = '0;
            col_d   = '0;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (rd_en_s) begin
          if (last_col_s) begin
            col_d = '0;
            row_d = row_q + RW'(1'b1);
          end else begin
            col_d = col_q + CW'(1'b1);
          end
          if (last_rd_s) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if ((fifo_cnt_q == 2'd0) && !infl_q) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // In-flight read tag and the 2-entry output FIFO.
  always_comb begin
    infl_d      = rd_en_s;
    infl_row_d  = infl_row_q;
    infl_col_d  = infl_col_q;
    infl_last_d = infl_last_q;
    fifo_data_d = fifo_data_q;
    fifo_row_d  = fifo_row_q;
    fifo_col_d  = fifo_col_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (rd_en_s) begin
      infl_row_d  = row_q;
      infl_col_d  = col_q;
      infl_last_d = last_rd_s;
    end else begin
      infl_last_d = 1'b0;
    end
    if (infl_q) begin
      fifo_data_d[wr_ptr_q] = bus.rd_data;
      fifo_row_d[wr_ptr_q]  = infl_row_q;
      fifo_col_d[wr_ptr_q]  = infl_col_q;
      fifo_last_d[wr_ptr_q] = infl_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    fifo_cnt_d = fifo_cnt_q + 2'(infl_q) - 2'(pop_s);
  end

  // State, counters, in-flight tag and FIFO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      infl_q      <= 1'b0;
      infl_row_q  <= '0;
      infl_col_q  <= '0;
      infl_last_q <= 1'b0;
      fifo_cnt_q  <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_row_q[i]  <= '0;
        fifo_col_q[i]  <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      row_q       <= row_d;
      col_q       <= col_d;
      infl_q      <= infl_d;
      infl_row_q  <= infl_row_d;
      infl_col_q  <= infl_col_d;
      infl_last_q <= infl_last_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_data_q <= fifo_data_d;
      fifo_row_q  <= fifo_row_d;
      fifo_col_q  <= fifo_col_d;
      fifo_last_q <= fifo_last_d;
    end
  end

  // Outputs decode straight from registers; the FIFO head is zeroed while empty.
  always_comb begin
    bus.rd_en   = rd_en_s;
    bus.rd_addr = rd_en_s ? AW'(addr_s) : '0;
    bus.out_valid = (fifo_cnt_q != 2'd0);
    if (fifo_cnt_q != 2'd0) begin
      bus.out_data    = fifo_data_q[rd_ptr_q];
      bus.out_row     = fifo_row_q[rd_ptr_q];
      bus.out_col_blk = fifo_col_q[rd_ptr_q];
      bus.out_last    = fifo_last_q[rd_ptr_q];
    end else begin
      bus.out_data    = '0;
      bus.out_row     = '0;
      bus.out_col_blk = '0;
      bus.out_last    = 1'b0;
    end
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

endmodule

// File: tb/tb_accum_table_read_ctrl.sv
// Randomized bench for accum_table_read_ctrl: a table model answers reads and a
// queue-based reference of the expected drain order checks every accepted word.
module tb_accum_table_read_ctrl;

  localparam int MAX_OUT_ROWS = 128;
  localparam int MAX_OUT_COLS = 128;
  localparam int SAR          = 16;
  localparam int SAC          = 16;
  localparam int DATA_W       = 32;
  localparam int NCB          = MAX_OUT_COLS / SAC;
  localparam int AW           = 10;
  localparam int RW           = 7;
  localparam int CW           = 3;
  localparam int WW           = SAC * DATA_W;

  typedef struct {
    logic [AW-1:0] addr;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] cfg_rows;
  logic [3:0] cfg_col_blks;
  logic       busy;
  logic       done;

  accum_table_read_ctrl_if #(.AW(AW), .WW(WW), .RW(RW), .CW(CW)) bus ();

  accum_table_read_ctrl #(
    .MAX_OUT_ROWS(MAX_OUT_ROWS), .MAX_OUT_COLS(MAX_OUT_COLS),
    .SYS_ARR_ROWS(SAR), .SYS_ARR_COLS(SAC), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows),
    .cfg_col_blks(cfg_col_blks), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;
  bit   rnd_ready = 1'b0;
  logic [7:0] salt = 8'd0;

  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];
  int n_done, n_busy, n_reads, n_words, issued, accepted;
  int first_valid_cyc, last_word_cyc, done_cyc, start_cyc;

  task automatic check_eq(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a, input logic [7:0] s);
    logic [WW-1:0] w;
    for (int l = 0; l < SAC; l++) w[l*DATA_W +: DATA_W] = {s, 8'(l), 6'd0, a};
    return w;
  endfunction

  // Table model: data for a read appears one cycle after rd_en, junk otherwise.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem_word(bus.rd_addr, salt);
    else           bus.rd_data <= {WW{1'b1}} ^ {(WW/8){salt}};
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor, sampled on the falling edge.
  initial begin
    logic          stall_prev;
    logic [WW-1:0] prev_data;
    logic [RW-1:0] prev_row;
    logic [CW-1:0] prev_col;
    logic          prev_last;
    logic          pop_v;
    exp_t          e;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        stall_prev = 1'b0;
      end else begin
        pop_v = bus.out_valid & bus.out_ready;
        if (done) begin
          n_done++;
          if (done_cyc < 0) done_cyc = cyc;
        end
        if (busy) n_busy++;
        if (bus.rd_en) begin
          check_eq("rd_while_busy", WW'(busy && !done), WW'(1));
          check_eq("rd_occupancy", WW'((issued - accepted - int'(pop_v)) < 2), WW'(1));
          if (addr_q.size() == 0) check_eq("rd_extra", WW'(1), WW'(0));
          else check_eq("rd_addr", WW'(bus.rd_addr), WW'(addr_q.pop_front()));
          issued++;
          n_reads++;
        end
        if (stall_prev) begin
          check_eq("hold_valid", WW'(bus.out_valid), WW'(1));
          check_eq("hold_data", bus.out_data, prev_data);
          check_eq("hold_meta", WW'({bus.out_row, bus.out_col_blk, bus.out_last}),
                   WW'({prev_row, prev_col, prev_last}));
        end
        if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (pop_v) begin
          if (exp_q.size() == 0) begin
            check_eq("out_extra", WW'(1), WW'(0));
          end else begin
            e = exp_q.pop_front();
            check_eq("out_data", bus.out_data, mem_word(e.addr, salt));
            check_eq("out_row", WW'(bus.out_row), WW'(e.row));
            check_eq("out_col_blk", WW'(bus.out_col_blk), WW'(e.col));
            check_eq("out_last", WW'(bus.out_last), WW'(e.last));
          end
          accepted++;
          n_words++;
          last_word_cyc = cyc;
        end
        stall_prev = bus.out_valid & ~bus.out_ready;
        prev_data  = bus.out_data;
        prev_row   = bus.out_row;
        prev_col   = bus.out_col_blk;
        prev_last  = bus.out_last;
      end
    end
  end

  // Builds the expected drain, clears run counters and pulses start.
  task automatic launch(input int rows, input int cols, input bit rnd);
    int a;
    exp_q.delete();
    addr_q.delete();
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        a = c * MAX_OUT_ROWS + (r / SAR) * SAR + (SAR - 1 - (r % SAR));
        addr_q.push_back(AW'(a));
        exp_q.push_back('{AW'(a), RW'(r), CW'(c), (r == rows - 1) && (c == cols - 1)});
      end
    end
    salt = 8'($urandom);
    rnd_ready = rnd;
    n_done = 0; n_busy = 0; n_reads = 0; n_words = 0; issued = 0; accepted = 0;
    first_valid_cyc = -1; last_word_cyc = -1; done_cyc = -1;
    mon_en = 1'b1;
    @(negedge clk);
    cfg_rows = 8'(rows);
    cfg_col_blks = 4'(cols);
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
    cfg_rows = 8'($urandom);
    cfg_col_blks = 4'($urandom);
  endtask

  task automatic run_drain(input int rows, input int cols, input bit rnd, input int restart_at);
    int total;
    total = rows * cols;
    launch(rows, cols, rnd);
    for (int i = 0; i < 6000 && n_done == 0; i++) begin
      @(posedge clk);
      #1;
      if (i == restart_at) begin
        start = 1'b1;
        cfg_rows = 8'd3;
        cfg_col_blks = 4'd1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (n_done == 0) check_eq("done_timeout", WW'(0), WW'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("done_count", WW'(n_done), WW'(1));
    check_eq("word_count", WW'(n_words), WW'(total));
    check_eq("read_count", WW'(n_reads), WW'(total));
    check_eq("exp_left", WW'(exp_q.size()), WW'(0));
    check_eq("busy_after", WW'(busy), WW'(0));
    if (total > 0) begin
      // Latency counted in edges from the edge that samples start.
      check_eq("first_valid_lat", WW'(first_valid_cyc - start_cyc), WW'(2));
      if (!rnd) check_eq("back_to_back", WW'(last_word_cyc - first_valid_cyc + 1), WW'(total));
    end else begin
      check_eq("zero_done_lat", WW'(done_cyc - start_cyc), WW'(0));
      check_eq("zero_busy_cycles", WW'(n_busy), WW'(1));
    end
  endtask

  initial begin
    int wait_i;
    rst_n = 1'b0;
    start = 1'b0;
    cfg_rows = 8'd0;
    cfg_col_blks = 4'd0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_outputs", WW'({bus.rd_en, bus.rd_addr, bus.out_valid, bus.out_row,
             bus.out_col_blk, bus.out_last, busy, done}), WW'(0));
    check_eq("rst_out_data", bus.out_data, WW'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_drain(1, 1, 1'b0, -1);
    run_drain(18, 2, 1'b0, -1);
    run_drain(18, 2, 1'b1, -1);
    run_drain(0, 3, 1'b0, -1);
    run_drain(5, 0, 1'b1, -1);
    run_drain(18, 2, 1'b0, 5);
    run_drain(128, 8, 1'b0, -1);
    for (int k = 0; k < 3; k++)
      run_drain(int'($urandom_range(1, 40)), int'($urandom_range(1, NCB)), 1'b1, -1);

    // Reset after 5 words, right after an edge that launched a read.
    launch(18, 2, 1'b1);
    wait_i = 0;
    while (wait_i < 2000 && !(n_words >= 5 && bus.rd_en)) begin
      @(negedge clk);
      wait_i++;
    end
    if (wait_i >= 2000) check_eq("rst_setup_timeout", WW'(0), WW'(1));
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_outputs", WW'({bus.rd_en, bus.rd_addr, bus.out_valid, bus.out_row,
             bus.out_col_blk, bus.out_last, busy, done}), WW'(0));
    check_eq("midrst_out_data", bus.out_data, WW'(0));
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("stale_discard", WW'({bus.out_valid, busy, bus.rd_en}), WW'(0));
    end
    run_drain(18, 2, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/accum_table_read_ctrl.md
ACCUM_TABLE_READ_CTRL -- requirements
Module: accum_table_read_ctrl

Interface
REQ-001 SHALL have parameter MAX_OUT_ROWS, default 128: max output matrix rows.
REQ-002 SHALL have parameter MAX_OUT_COLS, default 128: max output matrix columns.
REQ-003 SHALL have parameter SYS_ARR_ROWS, default 16: systolic array rows, i.e. rows per sub-matrix.
REQ-004 SHALL have parameter SYS_ARR_COLS, default 16: systolic array columns, i.e. elements per table word.
REQ-005 SHALL have parameter DATA_W, default 32: accumulator element width.
REQ-006 Derived values: NUM_ACCUM_ROWS = MAX_OUT_ROWS*(MAX_OUT_COLS/SYS_ARR_COLS); NCB = MAX_OUT_COLS/SYS_ARR_COLS; AW = $clog2(NUM_ACCUM_ROWS).
REQ-007 Port list, in order:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that launches a drain.
- cfg_rows  in  $clog2(MAX_OUT_ROWS)+1  output rows, 0..MAX_OUT_ROWS.
- cfg_col_blks  in  $clog2(NCB)+1  column blocks, 0..NCB.
- rd_en  out  1  table read strobe.
- rd_addr  out  AW  table read address.
- rd_data  in  SYS_ARR_COLS*DATA_W  table word, valid exactly 1 cycle after rd_en.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  SYS_ARR_COLS*DATA_W  output word.
- out_row  out  $clog2(MAX_OUT_ROWS)  output row of out_data.
- out_col_blk  out  $clog2(NCB)  column block of out_data.
- out_last  out  1  marks final word of the drain.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.

Function
REQ-008 Address for output row r, column block c SHALL be c*MAX_OUT_ROWS + (r/SYS_ARR_ROWS)*SYS_ARR_ROWS + (SYS_ARR_ROWS-1-(r%SYS_ARR_ROWS)), which inverts the write-side row reversal.
REQ-009 Traversal SHALL be row-major: r outer, 0..cfg_rows-1; c inner, 0..cfg_col_blks-1.
REQ-010 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-011 IDLE transitions:
- start=1 with both configs nonzero: latch the configs, enter RUN.
- start=1 with either config zero: enter DONE, issue no reads.
REQ-012 start SHALL be ignored in every state except IDLE, and the latched configs SHALL NOT change mid-drain.
REQ-013 In RUN, a read SHALL issue in a cycle only if (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready.
REQ-014 rd_data SHALL be captured into a 2-entry output FIFO one cycle after its rd_en, tagged with the row, column block and last flag of that read.
REQ-015 The FSM SHALL move RUN->DRAIN in the cycle it issues the last read.
REQ-016 The FSM SHALL move DRAIN->DONE when the FIFO is empty and no read is in flight.
REQ-017 DONE SHALL last exactly 1 cycle with done=1, then return to IDLE.
REQ-018 busy SHALL be 1 in RUN, DRAIN and DONE, and 0 in IDLE.
REQ-019 Output SHALL follow the valid/ready rule: once out_valid=1, out_valid, out_data, out_row, out_col_blk and out_last SHALL hold stable until out_ready=1.
REQ-020 With out_ready held at 1, throughput SHALL be 1 word per cycle, with first out_valid 2 cycles after start.
REQ-021 The FIFO SHALL never overflow, and no word SHALL be dropped or duplicated under any out_ready pattern.
REQ-022 rd_en SHALL be 0 outside RUN.

Reset
REQ-023 While rst_n=0 the block SHALL be in IDLE with these outputs at 0: rd_en, rd_addr, out_valid, out_data, out_row, out_col_blk, out_last, busy, done.
REQ-024 While rst_n=0, FIFO count, in-flight flag and counters SHALL be cleared.
REQ-025 Reset asserted mid-drain SHALL abort the drain immediately.
REQ-026 rd_data arriving after reset deassertion for a pre-reset read SHALL be discarded.

Verification
REQ-027 Single word: cfg_rows=1, cfg_col_blks=1, start, out_ready=1 -> one read, rd_addr=15; out_last=1 on that word; done pulses once.
REQ-028 Sequence: cfg_rows=18, cfg_col_blks=2, out_ready=1 -> rd_addr sequence 15,143,14,142,...,0,128,31,159,30,158; 36 words back-to-back; out_last only on (row 17, col_blk 1).
REQ-029 Backpressure: same config, out_ready random 50% -> 36 words, ordered and stable while stalled, matching a reference model; rd_en never issued with 2 words held.
REQ-030 Zero config: cfg_rows=0, start -> no rd_en; done 1 cycle after start; busy high for that one cycle only.
REQ-031 Start while busy: second start in RUN -> ignored, word count unchanged, single done.
REQ-032 Reset mid-drain: rst_n low after 5 words -> all outputs 0 immediately; a new start after release yields the full sequence from row 0.
